bus_grant_arbiter: RTL and testbench
====================================

# bus_grant_arbiter

Round-robin arbiter that shares the single internal CPU bus among up to 31 bus-driver requesters: registers, HI/LO, Z, PC, MDR, InPort and C. It issues a registered one-hot 32-bit grant that drives the bus-select encoder directly. It also issues the matching 5-bit select, which is 31 when the bus is idle. It inserts one turnaround cycle between owners so that two drivers are never enabled in the same cycle.

## Interface
- `NUM_REQ`, 24, number of requesters; legal range 1..31 (index 31 is reserved for idle).
- `TIMEOUT`, 16, maximum ownership cycles before a forced release; used only with the macro.

- `clk` in 1: system clock; all state changes on the rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request per driver; bit i = driver i.
- `release` in 1: one-cycle pulse from the current owner ending its tenure.
- `lock` in 1: the owner holds the bus; suppresses the timeout.
- `grant` out 32: registered one-hot grant; bits NUM_REQ..31 are always 0.
- `bus_sel` out 5: index of the granted driver, 31 when no grant.
- `busy` out 1: high while in OWN.
- `timeout_err` out 1: one-cycle pulse on a forced release.

## Operation
- States:
  - IDLE: no grant; arbitrates.
  - OWN: one driver granted.
  - TURN: one dead cycle with no grant; arbitrates.
- Arbitration (IDLE or TURN):
  - Scan `req` starting at `ptr+1` and wrap modulo NUM_REQ.
  - The first set bit wins and becomes `ptr`.
  - Next state is OWN with `grant[w]=1` and `bus_sel=w`.
  - If no request is set, next state is IDLE.
- Round-robin pointer:
  - `ptr` resets to NUM_REQ-1, so driver 0 has top priority after reset.
  - `ptr` updates only on a grant.
- OWN exit: leave OWN for TURN when any of the following holds.
  - `release`=1.
  - `req[owner]`=0; dropping the request counts as an implicit release.
  - The timeout fires (see Configuration).
- In OWN, `release` has no effect on arbitration for other requesters that cycle.
- A requester that releases and still has `req` high competes normally. It wins again only if no other requester lies between it and itself in round-robin order.
- `release` outside OWN is ignored.
- `lock` outside OWN is ignored.
- `bus_sel` always equals the binary index of the set `grant` bit, or 31 when `grant`=0. This matches the encoder's default output.
- The one-hot invariant holds in every cycle: `grant` has at most one bit set.

## Timing
- Reset (asynchronous, `clr_n`=0):
  - `grant`=0, `bus_sel`=31, `busy`=0, `timeout_err`=0.
  - State = IDLE, `ptr`=NUM_REQ-1, timeout counter = 0.
- Reset mid-ownership drops `grant` immediately, without waiting for a clock edge.
- Grant latency from IDLE: `req` sampled at edge k, so `grant`, `bus_sel` and `busy` are valid after edge k (one registered stage).
- Handoff:
  - `release` sampled at edge k gives `grant`=0 after edge k (TURN).
  - The next owner's grant is valid after edge k+1.
  - The minimum gap between owners is exactly one cycle.
- Simultaneous `release` and `req` from other drivers at the same edge: the new requesters are arbitrated during TURN and granted at the next edge.
- `req` bits at or above NUM_REQ do not exist; `grant` never sets bit 31.

## Configuration
- Macro: `BUS_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to OWN and increments each cycle in OWN while `lock`=0.
  - While `lock`=1 the counter holds its value.
  - When the counter reaches TIMEOUT-1 with `lock`=0, the next edge forces OWN→TURN and pulses `timeout_err` high for exactly one cycle.
  - The counter width is clog2(TIMEOUT)+1.
- Undefined:
  - No counter is built.
  - `timeout_err` is tied to 0.
  - `lock` is ignored.
  - Ownership ends only by `release` or by the owner dropping `req`.

## Test plan
- Reset: hold `clr_n`=0 with `req`=0xFFFFFF → `grant`=0, `bus_sel`=31, `busy`=0. Release reset → `grant`=0x00000001, `bus_sel`=0 one edge later.
- Single request: `req`=0x000008 from IDLE → after one edge `grant`=0x00000008, `bus_sel`=3. Pulse `release` → next cycle `grant`=0, `bus_sel`=31. Then IDLE.
- Round-robin: hold `req` bits 0, 5, 7 and pulse `release` after each grant → grant order 0, 5, 7, 0. Exactly one zero-grant cycle between owners.
- Wrap-around: owner 23 releases with `req` bits 2 and 23 set → next owner is 2, then 23.
- Timeout (`BUS_ARB_TIMEOUT_EN`, TIMEOUT=4): owner 1 with `lock`=0 → `grant` drops after 4 OWN cycles and `timeout_err` pulses once. Repeat with `lock`=1 → no drop over 20 cycles.
- Reset mid-operation: assert `clr_n`=0 between edges while owner 9 is granted → `grant`=0 and `bus_sel`=31 immediately, before the next edge. After reset, with `req`=0x000200, owner 9 is regranted.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// Round-robin CPU bus arbiter: registered one-hot grant plus bus-select index, one dead cycle between owners.
// Optional ownership timeout is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_grant_arbiter #(
  parameter int NUM_REQ = 24,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_clr_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_release,
  input  logic               i_lock,
  output logic [31:0]        o_grant,
  output logic [4:0]         o_bus_sel,
  output logic               o_busy,
  output logic               o_timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam logic [4:0] SEL_IDLE = 5'd31;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_grant, w_grant_nxt;
  logic [4:0]  r_bus_sel, w_sel_nxt;
  logic [4:0]  r_ptr, w_ptr_nxt;
  logic        r_to_err;

  logic [31:0] w_req32;
  logic        w_found;
  logic [4:0]  w_win;
  logic        w_timeout;
  logic        w_owner_done;

  always_comb begin
    w_req32 = '0;
    w_req32[NUM_REQ-1:0] = i_req;
  end

  // Scan from ptr+1 upward, wrapping at NUM_REQ; the first set request wins.
  always_comb begin
    logic [5:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, r_ptr} + 6'(i);
      if (idx >= 6'(NUM_REQ)) idx = idx - 6'(NUM_REQ);
      if (!w_found && w_req32[idx[4:0]]) begin
        w_found = 1'b1;
        w_win   = idx[4:0];
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_timeout = (r_state == ST_OWN) && !i_lock &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counter sits at zero outside OWN, so it is already clear on entry.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state != ST_OWN)
      w_cnt_nxt = '0;
    else if (!i_lock)
      w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end
`else
  logic [1:0] w_unused_cfg;
  assign w_unused_cfg = {i_lock, TIMEOUT[0]};
  assign w_timeout    = 1'b0;
`endif

  assign w_owner_done = i_release || !w_req32[r_bus_sel] || w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_bus_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE, ST_TURN: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = 32'd1 << w_win;
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_sel_nxt   = SEL_IDLE;
        end
      end
      ST_OWN: begin
        // Other requesters are not considered here; they compete in TURN.
        if (w_owner_done) begin
          w_state_nxt = ST_TURN;
          w_grant_nxt = '0;
          w_sel_nxt   = SEL_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_bus_sel <= SEL_IDLE;
      r_ptr     <= 5'(NUM_REQ - 1);
      r_to_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_bus_sel <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_to_err  <= w_timeout;
    end
  end

  assign o_grant       = r_grant;
  assign o_bus_sel     = r_bus_sel;
  assign o_busy        = (r_state == ST_OWN);
  assign o_timeout_err = r_to_err;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter: reset, single grant, round-robin, wrap, mid-ownership reset, timeout.
module tb_bus_grant_arbiter;
  localparam int NUM_REQ = 24;
  localparam int TB_TIMEOUT = 4;

  logic               clk;
  logic               clr_n;
  logic [NUM_REQ-1:0] req;
  logic               rel;
  logic               lock;
  logic [31:0]        grant;
  logic [4:0]         bus_sel;
  logic               busy;
  logic               timeout_err;

  int n_cmp;
  int n_fail;

  bus_grant_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TB_TIMEOUT)) dut (
    .i_clk         (clk),
    .i_clr_n       (clr_n),
    .i_req         (req),
    .i_release     (rel),
    .i_lock        (lock),
    .o_grant       (grant),
    .o_bus_sel     (bus_sel),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    req   = 24'hFFFFFF;
    rel   = 1'b0;
    lock  = 1'b0;
    step();
    step();
    n_cmp++; if (grant !== 32'h0) begin n_fail++; $display("FAIL reset_grant got %h want %h", grant, 32'h0); end
    n_cmp++; if (bus_sel !== 5'd31) begin n_fail++; $display("FAIL reset_sel got %0d want 31", bus_sel); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_toerr got %b want 0", timeout_err); end
    clr_n = 1'b1;
    step();
    n_cmp++; if (grant !== 32'h1) begin n_fail++; $display("FAIL post_reset_grant got %h want %h", grant, 32'h1); end
    n_cmp++; if (bus_sel !== 5'd0) begin n_fail++; $display("FAIL post_reset_sel got %0d want 0", bus_sel); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_busy got %b want 1", busy); end
    // owner 0 drops its request: implicit release
    req = '0;
    step();
    n_cmp++; if (grant !== 32'h0) begin n_fail++; $display("FAIL drop_req_grant got %h want %h", grant, 32'h0); end
    step();
  endtask

  task automatic test_single();
    req = 24'h000008;
    step();
    n_cmp++; if (grant !== 32'h8) begin n_fail++; $display("FAIL single_grant got %h want %h", grant, 32'h8); end
    n_cmp++; if (bus_sel !== 5'd3) begin n_fail++; $display("FAIL single_sel got %0d want 3", bus_sel); end
    rel = 1'b1;
    req = '0;
    step();
    rel = 1'b0;
    n_cmp++; if (grant !== 32'h0) begin n_fail++; $display("FAIL single_turn_grant got %h want %h", grant, 32'h0); end
    n_cmp++; if (bus_sel !== 5'd31) begin n_fail++; $display("FAIL single_turn_sel got %0d want 31", bus_sel); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_turn_busy got %b want 0", busy); end
    step();
    n_cmp++; if (grant !== 32'h0 || bus_sel !== 5'd31) begin n_fail++; $display("FAIL single_idle got %h/%0d want 0/31", grant, bus_sel); end
    // release and lock outside OWN are ignored
    rel  = 1'b1;
    lock = 1'b1;
    step();
    rel  = 1'b0;
    lock = 1'b0;
    n_cmp++; if (grant !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_release got %h/%b want 0/0", grant, busy); end
  endtask

  task automatic test_round_robin();
    logic [4:0] order [3];
    order[0] = 5'd5;
    order[1] = 5'd7;
    order[2] = 5'd0;
    // fresh reset so the pointer starts at NUM_REQ-1
    req = 24'h0000A1;
    #2 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    step();
    n_cmp++; if (grant !== 32'h1) begin n_fail++; $display("FAIL rr_first got %h want %h", grant, 32'h1); end
    for (int k = 0; k < 3; k++) begin
      rel = 1'b1;
      step();
      rel = 1'b0;
      n_cmp++; if (grant !== 32'h0) begin n_fail++; $display("FAIL rr_gap%0d got %h want 0", k, grant); end
      step();
      n_cmp++; if (grant !== (32'd1 << order[k]) || bus_sel !== order[k]) begin
        n_fail++; $display("FAIL rr_owner%0d got %h/%0d want %h/%0d", k, grant, bus_sel, 32'd1 << order[k], order[k]);
      end
    end
  endtask

  task automatic test_wrap();
    req = 24'h800000;
    step();
    n_cmp++; if (grant !== 32'h0) begin n_fail++; $display("FAIL wrap_gap0 got %h want 0", grant); end
    step();
    n_cmp++; if (grant !== 32'h00800000 || bus_sel !== 5'd23) begin n_fail++; $display("FAIL wrap_own23 got %h/%0d want 00800000/23", grant, bus_sel); end
    req = 24'h800004;
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    n_cmp++; if (grant !== 32'h4 || bus_sel !== 5'd2) begin n_fail++; $display("FAIL wrap_own2 got %h/%0d want 00000004/2", grant, bus_sel); end
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    n_cmp++; if (grant !== 32'h00800000 || bus_sel !== 5'd23) begin n_fail++; $display("FAIL wrap_back23 got %h/%0d want 00800000/23", grant, bus_sel); end
    req = '0;
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    n_cmp++; if (grant !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got %h/%b want 0/0", grant, busy); end
  endtask

  task automatic test_mid_reset();
    req = 24'h000200;
    step();
    n_cmp++; if (grant !== 32'h200 || bus_sel !== 5'd9) begin n_fail++; $display("FAIL mr_own9 got %h/%0d want 00000200/9", grant, bus_sel); end
    #2 clr_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 32'h0 || bus_sel !== 5'd31 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mr_async got %h/%0d/%b want 0/31/0", grant, bus_sel, busy);
    end
    clr_n = 1'b1;
    step();
    n_cmp++; if (grant !== 32'h200 || bus_sel !== 5'd9) begin n_fail++; $display("FAIL mr_regrant got %h/%0d want 00000200/9", grant, bus_sel); end
    req = '0;
    step();
    step();
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    req  = 24'h000002;
    lock = 1'b0;
    step();
    n_cmp++; if (grant !== 32'h2) begin n_fail++; $display("FAIL to_grant got %h want 2", grant); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (grant !== 32'h2 || timeout_err !== 1'b0) begin
        n_fail++; $display("FAIL to_hold%0d got %h/%b want 2/0", k, grant, timeout_err);
      end
    end
    step();
    n_cmp++; if (grant !== 32'h0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_fire got %h/%b want 0/1", grant, timeout_err); end
    lock = 1'b1;
    step();
    n_cmp++; if (grant !== 32'h2 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_regrant got %h/%b want 2/0", grant, timeout_err); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (grant !== 32'h2 || timeout_err !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL to_lock got %0d bad cycles want 0", bad); end
    lock = 1'b0;
    req  = '0;
    step();
    step();
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_mid_reset();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
